// File: rtl/ms_skid_stage_if.sv
// Valid/ready channel bundle for one ms_skid_stage: upstream (u2d) and downstream (d2u) sides.
// A word moves when valid and ready are both high at a rising clk edge; a producer holds
// its data stable while valid is high and ready is low, and valid never waits for ready.
interface ms_skid_stage_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] u2d_data_i;
  logic                  u2d_valid_i;
  logic                  u2d_ready_o;
  logic [DATA_WIDTH-1:0] d2u_data_o;
  logic                  d2u_valid_o;
  logic                  d2u_ready_i;
  logic [1:0]            dbg_state_o;

  modport slave (
    input  u2d_data_i, u2d_valid_i, d2u_ready_i,
    output u2d_ready_o, d2u_data_o, d2u_valid_o, dbg_state_o
  );

  modport master (
    output u2d_data_i, u2d_valid_i, d2u_ready_i,
    input  u2d_ready_o, d2u_data_o, d2u_valid_o, dbg_state_o
  );
endinterface

// File: rtl/ms_skid_stage.sv
// Registered valid/ready stage with a two-entry skid buffer; every output comes from a flop,
// so data, valid and ready are all cut combinationally between producer and consumer.
module ms_skid_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ms_skid_stage_if.slave  bus
);
  // State bits are {skid_vld, main_vld}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  ready_q, ready_d;
  logic                  accept, emit;

  assign accept = bus.u2d_valid_i & ready_q;
  assign emit   = state_q[0] & bus.d2u_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = bus.u2d_data_i;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_data_d = bus.u2d_data_i;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = bus.u2d_data_i;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is registered from the next state so it never depends on this cycle's inputs.
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.u2d_ready_o = ready_q;
  assign bus.d2u_valid_o = state_q[0];
  assign bus.d2u_data_o  = main_data_q;
  assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_ms_skid_stage.sv
// Bench for ms_skid_stage: one stand-alone stage checked every cycle against a two-deep FIFO
// model, plus two chained stages checked end to end for order, count and latency.
module tb_ms_skid_stage;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc++;

  ms_skid_stage_if #(.DATA_WIDTH(W)) s_if ();
  ms_skid_stage_if #(.DATA_WIDTH(W)) a_if ();
  ms_skid_stage_if #(.DATA_WIDTH(W)) b_if ();

  ms_skid_stage #(.DATA_WIDTH(W)) u_single (.clk(clk), .rst_n(rst), .bus(s_if));
  ms_skid_stage #(.DATA_WIDTH(W)) u_chain_a (.clk(clk), .rst_n(rst), .bus(a_if));
  ms_skid_stage #(.DATA_WIDTH(W)) u_chain_b (.clk(clk), .rst_n(rst), .bus(b_if));

  assign b_if.u2d_data_i  = a_if.d2u_data_o;
  assign b_if.u2d_valid_i = a_if.d2u_valid_o;
  assign a_if.d2u_ready_i = b_if.u2d_ready_o;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- single-stage model: FIFO of depth 2 ----------------
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last = '0;
  logic [W-1:0] s_out[$];
  bit           s_acc_last = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit emt;
    if (rst) begin
      m_q.delete();
      m_last     = '0;
      s_acc_last = 1'b0;
    end else begin
      acc = s_if.u2d_valid_i && (m_q.size() < 2);
      emt = (m_q.size() > 0) && s_if.d2u_ready_i;
      if (emt) s_out.push_back(m_q.pop_front());
      if (acc) m_q.push_back(s_if.u2d_data_i);
      if (m_q.size() > 0) m_last = m_q[0];
      s_acc_last = acc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_valid", {31'd0, s_if.d2u_valid_o}, {31'd0, m_q.size() > 0});
      chk("s_ready", {31'd0, s_if.u2d_ready_o}, {31'd0, m_q.size() < 2});
      chk("s_data",  {24'd0, s_if.d2u_data_o},  {24'd0, m_last});
      chk("s_state", {30'd0, s_if.dbg_state_o}, {30'd0, m_q.size() == 2, m_q.size() > 0});
    end
  end

  // ---------------- chain scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           acc_cyc_q[$];
  int           ch_rx = 0;
  bit           stream_mode = 1'b0;

  always @(posedge clk) begin
    int c;
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else begin
      if (b_if.d2u_valid_o && b_if.d2u_ready_i) begin
        ch_rx++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL ch_spurious: got word %0h expected none (cycle %0d)", b_if.d2u_data_o, cyc);
        end else begin
          chk("ch_order", {24'd0, b_if.d2u_data_o}, {24'd0, exp_q.pop_front()});
          c = acc_cyc_q.pop_front();
          if (stream_mode) chk("ch_latency", cyc - c, 2);
        end
      end
      if (a_if.u2d_valid_i && a_if.u2d_ready_o) begin
        exp_q.push_back(a_if.u2d_data_i);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic s_send(input logic [W-1:0] w);
    bit done = 1'b0;
    s_if.u2d_valid_i = 1'b1;
    s_if.u2d_data_i  = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (s_acc_last) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL s_send_timeout: got no accept expected accept of %0h", w);
    end
  endtask

  task automatic ch_send(input logic [W-1:0] w);
    bit done = 1'b0;
    bit r;
    a_if.u2d_valid_i = 1'b1;
    a_if.u2d_data_i  = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = a_if.u2d_ready_o;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL ch_send_timeout: got no accept expected accept of %0h", w);
    end
  endtask

  task automatic ch_drain(input int target, input string name);
    for (int i = 0; i < 100 && ch_rx < target; i++) @(posedge clk);
    #1;
    chk(name, ch_rx, target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit tx_done;
    s_if.u2d_valid_i = 1'b0;
    s_if.u2d_data_i  = '0;
    s_if.d2u_ready_i = 1'b0;
    a_if.u2d_valid_i = 1'b0;
    a_if.u2d_data_i  = '0;
    b_if.d2u_ready_i = 1'b0;

    // Reset held for 10 edges; outputs pinned to literals throughout.
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, s_if.d2u_valid_o}, 32'd0);
      chk("rst_ready", {31'd0, s_if.u2d_ready_o}, 32'd1);
      chk("rst_data",  {24'd0, s_if.d2u_data_o},  32'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, b_if.d2u_valid_o}, 32'd0);
    chk("post_rst_ready", {31'd0, a_if.u2d_ready_o}, 32'd1);

    // Streaming 0..15 through the chain with the sink always ready.
    @(posedge clk);
    #1;
    stream_mode      = 1'b1;
    b_if.d2u_ready_i = 1'b1;
    base             = ch_rx;
    for (int i = 0; i < 16; i++) begin
      a_if.u2d_valid_i = 1'b1;
      a_if.u2d_data_i  = W'(i);
      @(negedge clk);
      chk("stream_ready", {31'd0, a_if.u2d_ready_o}, 32'd1);
      @(posedge clk);
      #1;
    end
    a_if.u2d_valid_i = 1'b0;
    ch_drain(base + 16, "stream_count");
    stream_mode = 1'b0;

    // Backpressure on the single stage: 16 and 17 fill it, 18 waits.
    base = s_out.size();
    s_if.u2d_valid_i = 1'b1;
    s_if.u2d_data_i  = 8'd16;
    @(posedge clk);
    #1 s_if.u2d_data_i = 8'd17;
    @(posedge clk);
    #1 s_if.u2d_data_i = 8'd18;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'd0, s_if.u2d_ready_o}, 32'd0);
      chk("bp_valid", {31'd0, s_if.d2u_valid_o}, 32'd1);
      chk("bp_data",  {24'd0, s_if.d2u_data_o},  32'd16);
      @(posedge clk);
      #1;
    end
    s_if.d2u_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_ready", {31'd0, s_if.u2d_ready_o}, 32'd1);
    chk("drain_data",  {24'd0, s_if.d2u_data_o},  32'd17);
    s_send(8'd18);
    s_send(8'd19);
    s_send(8'd20);
    s_if.u2d_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_out_count", s_out.size() - base, 5);
    for (int i = 0; i < 5 && base + i < s_out.size(); i++)
      chk("bp_out_word", {24'd0, s_out[base + i]}, 32'(16 + i));

    // Random traffic on the single stage, model compared every cycle.
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          s_if.u2d_valid_i = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          s_send(W'($urandom_range(0, 255)));
        end
        s_if.u2d_valid_i = 1'b0;
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk);
          #1 s_if.d2u_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    s_if.d2u_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Bubbly traffic 17..32 through the chain.
    base = ch_rx;
    for (int w = 17; w <= 32; w++) begin
      ch_send(W'(w));
      a_if.u2d_valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    ch_drain(base + 16, "bubbly_count");

    // Random traffic through the chain with a random sink.
    base    = ch_rx;
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          a_if.u2d_valid_i = 1'b0;
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          ch_send(W'($urandom_range(0, 255)));
        end
        a_if.u2d_valid_i = 1'b0;
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk);
          #1 b_if.d2u_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    b_if.d2u_ready_i = 1'b1;
    ch_drain(base + 150, "rand_chain_count");

    // Mid-stream reset with two words buffered in the single stage.
    s_if.d2u_ready_i = 1'b0;
    s_send(8'hA1);
    s_send(8'hA2);
    s_if.u2d_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", {31'd0, s_if.u2d_ready_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    s_if.d2u_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, s_if.d2u_valid_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, s_if.u2d_ready_o}, 32'd1);
      chk("mid_rst_data",  {24'd0, s_if.d2u_data_o},  32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ms_skid_stage.md
Name: ms_skid_stage

Overview:
Single-clock valid/ready pipeline register stage with a two-entry skid buffer. It breaks the combinational path on data, valid and ready between an upstream producer and a downstream consumer. It sustains one transfer per cycle and preserves word order. Stages may be chained back-to-back, with the d2u side of one stage feeding the u2d side of the next.

Parameters:
DATA_WIDTH, 8, width of the payload in bits.

Ports:
clk  in  1  clock; all logic is rising-edge triggered.
rst_n  in  1  reset, synchronous, active-high (reset is applied when rst_n=1 at a rising clk edge).
u2d_data_i  in  DATA_WIDTH  upstream payload.
u2d_valid_i  in  1  upstream payload valid.
u2d_ready_o  out  1  stage can accept a word this cycle.
d2u_data_o  out  DATA_WIDTH  payload presented downstream.
d2u_valid_o  out  1  downstream payload valid.
d2u_ready_i  in  1  downstream accepts this cycle.

Behaviour:
- Handshake events:
  - accept = u2d_valid_i & u2d_ready_o
  - emit = d2u_valid_o & d2u_ready_i
  - Both are sampled at the rising edge of clk.
- Storage:
  - main register (main_data, main_vld) drives d2u_data_o and d2u_valid_o directly.
  - skid register (skid_data, skid_vld).
- All outputs come straight from flops, with no combinational input-to-output path:
  - u2d_ready_o = !skid_vld, registered.
  - d2u_valid_o = main_vld.
  - d2u_data_o = main_data.
- Reset values: main_vld=0, skid_vld=0, d2u_valid_o=0, d2u_data_o=0, skid_data=0, u2d_ready_o=1. A reset mid-operation discards all buffered words.
- States are encoded by {skid_vld, main_vld}. EMPTY=00, ONE=01, FULL=11; 10 is illegal and never reached.
- Transitions from EMPTY:
  - accept -> ONE; main_data <= u2d_data_i.
  - else stay in EMPTY.
- Transitions from ONE:
  - accept & emit -> ONE; main_data <= u2d_data_i.
  - accept & !emit -> FULL; skid_data <= u2d_data_i.
  - !accept & emit -> EMPTY.
  - neither -> hold.
- Transitions from FULL (accept cannot occur because ready=0):
  - emit -> ONE; main_data <= skid_data; ready returns to 1 the next cycle.
  - else hold.
- Latency: a word accepted at edge N is valid on d2u at edge N (visible after that edge) and can be emitted at edge N+1. Two chained stages give 2 cycles of latency.
- Throughput: with d2u_ready_i held at 1, one word per cycle indefinitely, with no bubbles inserted.
- Backpressure capacity: 2 words per stage.
  - u2d_ready_o deasserts in the cycle after the second un-emitted word is accepted.
  - A word offered while ready=1 is never dropped.
- While d2u_valid_o=1 and d2u_ready_i=0, d2u_data_o and d2u_valid_o hold stable.
- When d2u_valid_o=0, d2u_data_o retains its last value and never goes X.
- Order is strictly FIFO, with no duplication and no loss.
- u2d_valid_i is ignored when u2d_ready_o=0. The upstream holds its data until accept.
- Ready may rise or fall without regard to valid. The stage must not depend on valid/ready ordering.

Test Plan:
- Reset: hold rst_n=1 for 10 cycles, then release -> d2u_valid_o=0, d2u_data_o=0, u2d_ready_o=1 throughout.
- Streaming through two chained stages:
  - Stimulus: d2u_ready_i=1 at the sink; send 0..15 with valid high continuously.
  - Response: sink receives 0..15 in order, one per cycle, first word 2 cycles after its accept. u2d_ready_o stays 1.
- Backpressure on a single stage:
  - Stimulus: d2u_ready_i=0; offer 16 then 17.
  - Response: both are accepted; u2d_ready_o=0 the next cycle; d2u_data_o=16 held stable.
  - Then raise d2u_ready_i -> 16 then 17 are emitted on consecutive cycles, and ready returns to 1.
- Simultaneous accept+emit in FULL→ONE→ONE:
  - Stimulus: after draining one skid word, keep both sides active with 18,19,20.
  - Response: outputs 16,17,18,19,20 in order with no gap and no duplicate.
- Bubbly traffic through two chained stages: send 17..32 with valid low for one cycle between words -> sink receives 17..32 exactly once each, in order.
- Mid-stream reset: with 2 words buffered, assert rst_n=1 for one edge -> d2u_valid_o=0 and u2d_ready_o=1 after that edge; the buffered words are never emitted.
